board_write_ctl: RTL and testbench

Write-port controller for one `board_mem` instance (my board or enemy board). It owns the memory's single write port and shares it between two requesters: the ship-placement logic and the shot-marking logic. It also contains a built-in clear engine that wipes the whole 12x12 grid to zero on command. It runs on `control_clk` and drives `write_addr` / `write_data` / `write_enable` of the board memory directly.

---
 rtl/board_write_ctl.sv | 122 ++++++++++++
 tb/tb_board_write_ctl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_write_ctl.sv
// Write-port controller for one board_mem: arbitrates placement and shot
// writes (round-robin) and runs a full-grid clear sweep on command.
module board_write_ctl #(
   parameter int X_SIZE       = 12,
   parameter int Y_SIZE       = 12,
   parameter int X_ADDR_WIDTH = 4,
   parameter int Y_ADDR_WIDTH = 4,
   parameter int DATA_WIDTH   = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clear_req,
   input  logic                                 place_req,
   input  logic [X_ADDR_WIDTH-1:0]              place_x,
   input  logic [Y_ADDR_WIDTH-1:0]              place_y,
   input  logic [DATA_WIDTH-1:0]                place_data,
   output logic                                 place_ack,
   input  logic                                 shot_req,
   input  logic [X_ADDR_WIDTH-1:0]              shot_x,
   input  logic [Y_ADDR_WIDTH-1:0]              shot_y,
   input  logic [DATA_WIDTH-1:0]                shot_data,
   output logic                                 shot_ack,
   output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0]                write_data,
   output logic                                 write_enable,
   output logic                                 busy,
   output logic                                 err_oob
);

   localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
   localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t                  state;
   logic [X_ADDR_WIDTH-1:0] cx, nx, sel_x;
   logic [Y_ADDR_WIDTH-1:0] cy, ny, sel_y;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    last_shot;
   logic                    gnt_shot;
   logic                    in_range;
   logic                    sweep_done;

   // Tie goes to whichever requester was not granted last.
   always_comb begin
      gnt_shot = shot_req && (!place_req || !last_shot);
      sel_x    = gnt_shot ? shot_x : place_x;
      sel_y    = gnt_shot ? shot_y : place_y;
      sel_data = gnt_shot ? shot_data : place_data;
      in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
   end

   always_comb begin
      nx = cx + 1'b1;
      ny = cy;
      if (cx == X_LAST) begin
         nx = '0;
         ny = cy + 1'b1;
      end
      sweep_done = (cx == X_LAST) && (cy == Y_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cx           <= '0;
         cy           <= '0;
         last_shot    <= 1'b1;
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         place_ack    <= 1'b0;
         shot_ack     <= 1'b0;
         busy         <= 1'b0;
         err_oob      <= 1'b0;
      end else begin
         place_ack    <= 1'b0;
         shot_ack     <= 1'b0;
         err_oob      <= 1'b0;
         write_enable <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear_req) begin
                  state        <= CLEAR;
                  cx           <= '0;
                  cy           <= '0;
                  busy         <= 1'b1;
                  write_enable <= 1'b1;
                  write_addr   <= '0;
                  write_data   <= '0;
               end else if (place_req || shot_req) begin
                  state        <= WRITE;
                  last_shot    <= gnt_shot;
                  write_enable <= in_range;
                  write_addr   <= {sel_y, sel_x};
                  write_data   <= sel_data;
                  place_ack    <= !gnt_shot;
                  shot_ack     <= gnt_shot;
                  err_oob      <= !in_range;
               end
            end
            WRITE: begin
               state <= IDLE;
            end
            CLEAR: begin
               if (sweep_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cx           <= nx;
                  cy           <= ny;
                  write_enable <= 1'b1;
                  write_addr   <= {ny, nx};
                  write_data   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_write_ctl.sv
// Scoreboard bench for board_write_ctl: stimulus pushes expected
// write/ack events, a negedge monitor pops and compares them.
module tb_board_write_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_req, place_req, shot_req;
   logic [3:0] place_x, place_y, shot_x, shot_y;
   logic [1:0] place_data, shot_data;
   logic       place_ack, shot_ack, write_enable, busy, err_oob;
   logic [7:0] write_addr;
   logic [1:0] write_data;

   board_write_ctl dut (
      .clk(clk), .rst(rst), .clear_req(clear_req),
      .place_req(place_req), .place_x(place_x), .place_y(place_y),
      .place_data(place_data), .place_ack(place_ack),
      .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
      .shot_data(shot_data), .shot_ack(shot_ack),
      .write_addr(write_addr), .write_data(write_data),
      .write_enable(write_enable), .busy(busy), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       we;
      logic [7:0] addr;
      logic [1:0] data;
      logic       pa;
      logic       sa;
      logic       err;
      logic       bsy;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   logic rst_d = 1'b1;
   logic fin = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   run = 0;
   int   busy_first = -1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_d <= rst;
   end

   // Monitor: all checking and counting happens here.
   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (busy === 1'b1) run = run + 1;
      else if (run != 0) begin
         if (busy_first < 0) busy_first = run;
         run = 0;
      end
      if (rst_d === 1'b0) begin
         n_cmp = n_cmp + 1;
         if ({write_enable, write_addr, write_data, place_ack,
              shot_ack, busy, err_oob} !== 15'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_zero cyc=%0d we=%b addr=%h data=%b pa=%b sa=%b busy=%b err=%b required all 0",
                     cyc, write_enable, write_addr, write_data,
                     place_ack, shot_ack, busy, err_oob);
         end
      end else if ((write_enable | place_ack | shot_ack | err_oob) === 1'b1) begin
         n_cmp = n_cmp + 1;
         if (sb.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL unexpected cyc=%0d we=%b addr=%h data=%b pa=%b sa=%b err=%b required no event",
                     cyc, write_enable, write_addr, write_data,
                     place_ack, shot_ack, err_oob);
         end else begin
            e  = sb.pop_front();
            ok = (cyc == e.cyc) && (write_enable === e.we) &&
                 (place_ack === e.pa) && (shot_ack === e.sa) &&
                 (err_oob === e.err) && (busy === e.bsy);
            if (e.we && ((write_addr !== e.addr) || (write_data !== e.data)))
               ok = 1'b0;
            if (!ok) begin
               n_bad = n_bad + 1;
               $display("FAIL event cyc=%0d we=%b addr=%h data=%b pa=%b sa=%b err=%b busy=%b required cyc=%0d we=%b addr=%h data=%b pa=%b sa=%b err=%b busy=%b",
                        cyc, write_enable, write_addr, write_data, place_ack,
                        shot_ack, err_oob, busy, e.cyc, e.we, e.addr,
                        e.data, e.pa, e.sa, e.err, e.bsy);
            end
         end
      end
      if (fin) begin
         n_cmp = n_cmp + 1;
         if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL missing_events left=%0d required 0", sb.size());
         end
         n_cmp = n_cmp + 1;
         if (busy_first != 144) begin
            n_bad = n_bad + 1;
            $display("FAIL busy_len got=%0d required 144", busy_first);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push(input int c, input logic we, input logic [7:0] addr,
                       input logic [1:0] data, input logic pa,
                       input logic sa, input logic err, input logic bsy);
      exp_t e;
      e.cyc = c; e.we = we; e.addr = addr; e.data = data;
      e.pa = pa; e.sa = sa; e.err = err; e.bsy = bsy;
      sb.push_back(e);
   endtask

   task automatic set_place(input logic r, input logic [3:0] x,
                            input logic [3:0] y, input logic [1:0] d);
      place_req = r; place_x = x; place_y = y; place_data = d;
   endtask

   task automatic set_shot(input logic r, input logic [3:0] x,
                           input logic [3:0] y, input logic [1:0] d);
      shot_req = r; shot_x = x; shot_y = y; shot_data = d;
   endtask

   initial begin
      int k;
      rst = 1'b0;
      clear_req = 1'b0;
      set_place(1'b0, 4'd0, 4'd0, 2'd0);
      set_shot(1'b0, 4'd0, 4'd0, 2'd0);
      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         clear_req = 1'($urandom);
         set_place(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
         set_shot(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
         tick();
      end
      rst = 1'b1;
      clear_req = 1'b0;
      set_place(1'b0, 4'd0, 4'd0, 2'd0);
      set_shot(1'b0, 4'd0, 4'd0, 2'd0);
      wait_until(cyc + 4);

      // Single placement
      k = cyc;
      set_place(1'b1, 4'd3, 4'd5, 2'b01);
      push(k + 1, 1'b1, 8'h53, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_until(k + 1);
      place_req = 1'b0;
      wait_until(k + 6);

      // Corner cell still in range
      k = cyc;
      set_place(1'b1, 4'd11, 4'd11, 2'b11);
      push(k + 1, 1'b1, 8'hBB, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_until(k + 1);
      place_req = 1'b0;
      wait_until(k + 4);

      // y out of range
      k = cyc;
      set_place(1'b1, 4'd0, 4'd12, 2'b10);
      push(k + 1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_until(k + 1);
      place_req = 1'b0;
      wait_until(k + 4);

      // x out of range (shot); last grant becomes shot
      k = cyc;
      set_shot(1'b1, 4'd12, 4'd0, 2'b10);
      push(k + 1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_until(k + 1);
      shot_req = 1'b0;
      wait_until(k + 4);

      // Round-robin, placement first after a shot grant
      k = cyc;
      set_place(1'b1, 4'd1, 4'd1, 2'b10);
      set_shot(1'b1, 4'd2, 4'd2, 2'b11);
      for (int i = 0; i < 3; i++) begin
         push(k + 1 + 4 * i, 1'b1, 8'h11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
         push(k + 3 + 4 * i, 1'b1, 8'h22, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      wait_until(k + 11);
      place_req = 1'b0;
      shot_req  = 1'b0;
      wait_until(k + 16);

      // clear_req landing in WRITE is dropped
      k = cyc;
      set_place(1'b1, 4'd7, 4'd3, 2'b01);
      push(k + 1, 1'b1, 8'h37, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_until(k + 1);
      place_req = 1'b0;
      clear_req = 1'b1;
      wait_until(k + 2);
      clear_req = 1'b0;
      wait_until(k + 6);

      // Full clear with a shot waiting; a second clear pulse is ignored
      k = cyc;
      clear_req = 1'b1;
      set_shot(1'b1, 4'd4, 4'd7, 2'b01);
      for (int y = 0; y < 12; y++)
         for (int x = 0; x < 12; x++)
            push(k + 1 + y * 12 + x, 1'b1, {4'(y), 4'(x)}, 2'b00,
                 1'b0, 1'b0, 1'b0, 1'b1);
      push(k + 146, 1'b1, 8'h74, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_until(k + 1);
      clear_req = 1'b0;
      wait_until(k + 20);
      clear_req = 1'b1;
      wait_until(k + 21);
      clear_req = 1'b0;
      wait_until(k + 146);
      shot_req = 1'b0;
      wait_until(k + 151);

      // Reset during clear write #50, then a normal placement
      k = cyc;
      clear_req = 1'b1;
      for (int i = 0; i < 50; i++)
         push(k + 1 + i, 1'b1, {4'(i / 12), 4'(i % 12)}, 2'b00,
              1'b0, 1'b0, 1'b0, 1'b1);
      wait_until(k + 1);
      clear_req = 1'b0;
      wait_until(k + 50);
      rst = 1'b0;
      wait_until(k + 52);
      rst = 1'b1;
      set_place(1'b1, 4'd9, 4'd2, 2'b01);
      push(k + 53, 1'b1, 8'h29, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_until(k + 53);
      place_req = 1'b0;
      wait_until(k + 60);

      fin = 1'b1;
      wait_until(cyc + 5);
      $display("FAIL monitor_did_not_finish");
      $fatal(1);
   end

endmodule
